// File: rtl/qd_sram_pkg.sv
// Shared types and constants for the timed SRAM access sequencer.
// Holds the state encoding, default phase timing and the debug word layout.
package qd_sram_pkg;

  localparam int DEF_ADDR_W     = 21;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_STROBE_CYC = 2;
  localparam int DEF_HOLD_CYC   = 1;

  localparam int CNT_W   = 5;
  localparam int STATE_W = 3;
  localparam int DBG_W   = STATE_W + CNT_W;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3
  } state_t;

  // Debug word: state in the top bits, phase count in the low bits.
  function automatic logic [DBG_W-1:0] pack_debug(input state_t st, input logic [CNT_W-1:0] cnt);
    return {st, cnt};
  endfunction

endpackage

// File: rtl/sram_access_seq_cyc_timer.sv
// Loadable down-counter shared by the SETUP, STROBE and HOLD phases.
// tc is high while the count sits at zero, i.e. in the last cycle of a phase.
module cyc_timer
  import qd_sram_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  logic [CNT_W-1:0] count_r;

  // Phase counter: reload on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= CNT_ZERO;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != CNT_ZERO) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign tc    = (count_r == CNT_ZERO);

endmodule

// File: rtl/sram_access_seq.sv
// Timed SRAM access sequencer: turns a read/write request into registered
// CE/OE/WE strobes with programmable setup/strobe/hold, with optional address post-increment.
module sram_access_seq
  import qd_sram_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              load_addr,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inc_en,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [DBG_W-1:0]  debug
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0]  STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0]  HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  state_t              state_r, state_nx_s;
  logic                tmr_load_s, tc_s, accept_s, dir_nx_s;
  logic [CNT_W-1:0]    tmr_val_s, count_s;
  logic                ce_n_r, oe_n_r, we_n_r, drive_en_r, done_r;
  logic                dir_r, inc_r;
  logic [DATA_W-1:0]   wdata_r, rd_data_r;
  logic [ADDR_W-1:0]   addr_r;

  cyc_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .count    (count_s),
    .tc       (tc_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; the timer is reloaded on every phase entry.
  always_comb begin
    state_nx_s = state_r;
    tmr_load_s = 1'b0;
    tmr_val_s  = CNT_ZERO;
    accept_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rd_req || wr_req) begin
          state_nx_s = ST_SETUP;
          tmr_load_s = 1'b1;
          tmr_val_s  = SETUP_LD;
          accept_s   = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (tc_s) begin
          state_nx_s = ST_STROBE;
          tmr_load_s = 1'b1;
          tmr_val_s  = STROBE_LD;
        end else begin
          state_nx_s = ST_SETUP;
        end
      end
      ST_STROBE: begin
        if (tc_s) begin
          state_nx_s = ST_HOLD;
          tmr_load_s = 1'b1;
          tmr_val_s  = HOLD_LD;
        end else begin
          state_nx_s = ST_STROBE;
        end
      end
      ST_HOLD: begin
        if (tc_s) begin
          state_nx_s = ST_IDLE;
          tmr_load_s = 1'b1;
        end else begin
          state_nx_s = ST_HOLD;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        tmr_load_s = 1'b1;
      end
    endcase
  end

  // Write wins when both requests arrive together.
  assign dir_nx_s = accept_s ? wr_req : dir_r;

  // Strobes, bus enable, captured request and address are all registered off the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ce_n_r     <= 1'b1;
      oe_n_r     <= 1'b1;
      we_n_r     <= 1'b1;
      drive_en_r <= 1'b0;
      done_r     <= 1'b0;
      dir_r      <= 1'b0;
      inc_r      <= 1'b0;
      wdata_r    <= {DATA_W{1'b0}};
      rd_data_r  <= {DATA_W{1'b0}};
      addr_r     <= {ADDR_W{1'b0}};
    end else begin
      ce_n_r     <= (state_nx_s == ST_IDLE);
      oe_n_r     <= !((state_nx_s == ST_STROBE) && !dir_nx_s);
      we_n_r     <= !((state_nx_s == ST_STROBE) && dir_nx_s);
      drive_en_r <= (state_nx_s != ST_IDLE) && dir_nx_s;
      done_r     <= (state_r == ST_HOLD) && tc_s;
      if (accept_s) begin
        dir_r   <= wr_req;
        wdata_r <= wr_data;
        inc_r   <= inc_en;
      end
      if ((state_r == ST_IDLE) && load_addr) begin
        addr_r <= addr_in;
      end else if ((state_r == ST_HOLD) && tc_s && inc_r) begin
        addr_r <= addr_r + ADDR_ONE;
      end
      if ((state_r == ST_STROBE) && tc_s && !dir_r) begin
        rd_data_r <= sram_data;
      end
    end
  end

  assign sram_data = drive_en_r ? wdata_r : {DATA_W{1'bz}};
  assign sram_ce_n = ce_n_r;
  assign sram_oe_n = oe_n_r;
  assign sram_we_n = we_n_r;
  assign sram_addr = addr_r;
  assign rd_data   = rd_data_r;
  assign done      = done_r;
  assign busy      = (state_r != ST_IDLE);
  assign debug     = pack_debug(state_r, count_s);

endmodule

// File: tb/tb_sram_access_seq.sv
// Directed bench for sram_access_seq with a tiny SRAM read model on the data bus.
module tb_sram_access_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [20:0] addr_in = 21'h0;
  logic        load_addr = 1'b0, rd_req = 1'b0, wr_req = 1'b0, inc_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        busy, done, sram_ce_n, sram_oe_n, sram_we_n;
  logic [7:0]  rd_data, debug;
  logic [20:0] sram_addr;
  wire  [7:0]  sram_data;
  logic [7:0]  mem_q;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_access_seq dut (
    .clk(clk), .reset(reset), .addr_in(addr_in), .load_addr(load_addr),
    .rd_req(rd_req), .wr_req(wr_req), .wr_data(wr_data), .inc_en(inc_en),
    .busy(busy), .done(done), .rd_data(rd_data), .sram_addr(sram_addr),
    .sram_data(sram_data), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .debug(debug)
  );

  // SRAM read model: 0x3C at 0x00010, 0x77 elsewhere, driven only while OE is low.
  assign mem_q     = (sram_addr == 21'h00010) ? 8'h3C : 8'h77;
  assign sram_data = sram_oe_n ? 8'bzzzz_zzzz : mem_q;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One access; samples k=0..5 are taken just after edges E0..E5.
  task automatic access(input logic do_rd, input logic do_wr, input logic do_load,
                        input logic [20:0] a, input logic [7:0] d, input logic inc,
                        output int we_cnt, output int oe_cnt, output int done_at,
                        output int done_cnt, output logic [20:0] a_seen,
                        output logic [7:0] d_seen, output logic [7:0] dbg1);
    rd_req = do_rd; wr_req = do_wr; load_addr = do_load; addr_in = a; wr_data = d; inc_en = inc;
    tick();
    rd_req = 1'b0; wr_req = 1'b0; load_addr = 1'b0; inc_en = 1'b0; wr_data = 8'h00;
    we_cnt = 0; oe_cnt = 0; done_at = -1; done_cnt = 0;
    a_seen = 21'h0; d_seen = 8'h00; dbg1 = 8'h00;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      if (!sram_we_n) we_cnt++;
      if (!sram_oe_n) oe_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k == 1) begin
        a_seen = sram_addr;
        d_seen = sram_data;
        dbg1   = debug;
      end
    end
  endtask

  initial begin
    int we_c, oe_c, d_at, d_c, dn;
    logic [20:0] a_s;
    logic [7:0]  d_s, dbg_s;

    repeat (2) tick();
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_ce", sram_ce_n, 1'b1);
    check_val("rst_oe", sram_oe_n, 1'b1);
    check_val("rst_we", sram_we_n, 1'b1);
    check_val("rst_rdata", rd_data, 8'h00);
    check_val("rst_addr", sram_addr, 21'h0);
    check_val("rst_debug", debug, 8'h00);
    reset = 1'b0;
    tick();

    // Write 0xA5 to 0x1F000
    access(1'b0, 1'b1, 1'b1, 21'h1F000, 8'hA5, 1'b0, we_c, oe_c, d_at, d_c, a_s, d_s, dbg_s);
    check_val("wr_we_cycles", we_c, 2);
    check_val("wr_oe_cycles", oe_c, 0);
    check_val("wr_done_at", d_at, 4);
    check_val("wr_done_cnt", d_c, 1);
    check_val("wr_addr", a_s, 21'h1F000);
    check_val("wr_data", d_s, 8'hA5);
    check_val("wr_debug_strobe", dbg_s, 8'h41);
    check_val("wr_busy_end", busy, 1'b0);

    // Read from 0x00010
    access(1'b1, 1'b0, 1'b1, 21'h00010, 8'h00, 1'b0, we_c, oe_c, d_at, d_c, a_s, d_s, dbg_s);
    check_val("rd_oe_cycles", oe_c, 2);
    check_val("rd_we_cycles", we_c, 0);
    check_val("rd_done_at", d_at, 4);
    check_val("rd_data", rd_data, 8'h3C);
    check_val("rd_addr", a_s, 21'h00010);
    check_val("rd_addr_noinc", sram_addr, 21'h00010);

    // Increment wrap at the top of the address space
    access(1'b0, 1'b1, 1'b1, 21'h1FFFFF, 8'h01, 1'b1, we_c, oe_c, d_at, d_c, a_s, d_s, dbg_s);
    check_val("wrap_addr1", a_s, 21'h1FFFFF);
    check_val("wrap_after1", sram_addr, 21'h0);
    access(1'b0, 1'b1, 1'b0, 21'h0, 8'h02, 1'b1, we_c, oe_c, d_at, d_c, a_s, d_s, dbg_s);
    check_val("wrap_addr2", a_s, 21'h0);
    check_val("wrap_after2", sram_addr, 21'h1);
    check_val("rd_data_stable", rd_data, 8'h3C);

    // Both requests together: write wins
    access(1'b1, 1'b1, 1'b1, 21'h00020, 8'h5C, 1'b0, we_c, oe_c, d_at, d_c, a_s, d_s, dbg_s);
    check_val("both_we", we_c, 2);
    check_val("both_oe", oe_c, 0);
    check_val("both_data", d_s, 8'h5C);

    // load_addr and requests while busy are ignored
    wr_req = 1'b1; wr_data = 8'h33;
    tick();
    wr_req = 1'b0; load_addr = 1'b1; addr_in = 21'h0ABCD; rd_req = 1'b1;
    tick();
    check_val("busy_addr_strobe", sram_addr, 21'h00020);
    tick();
    tick();
    load_addr = 1'b0; rd_req = 1'b0;
    tick();
    check_val("busy_done", done, 1'b1);
    tick();
    check_val("busy_noqueue", busy, 1'b0);
    check_val("busy_addr_kept", sram_addr, 21'h00020);

    // Reset asserted during STROBE
    load_addr = 1'b1; addr_in = 21'h0; wr_req = 1'b1; inc_en = 1'b1; wr_data = 8'hC3;
    tick();
    load_addr = 1'b0; wr_req = 1'b0; inc_en = 1'b0;
    tick();
    check_val("rst_mid_we_before", sram_we_n, 1'b0);
    reset = 1'b1;
    #1;
    check_val("rst_mid_we", sram_we_n, 1'b1);
    check_val("rst_mid_ce", sram_ce_n, 1'b1);
    check_val("rst_mid_busy", busy, 1'b0);
    tick();
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) dn++;
    end
    check_val("rst_mid_nodone", dn, 0);
    check_val("rst_mid_addr", sram_addr, 21'h0);

    // Back-to-back request accepted in the done cycle
    load_addr = 1'b1; addr_in = 21'h00100; wr_req = 1'b1; inc_en = 1'b1; wr_data = 8'h10;
    tick();
    load_addr = 1'b0; wr_req = 1'b0; inc_en = 1'b0;
    repeat (4) tick();
    check_val("b2b_done", done, 1'b1);
    wr_req = 1'b1; inc_en = 1'b1; wr_data = 8'h11;
    tick();
    wr_req = 1'b0; inc_en = 1'b0;
    check_val("b2b_busy", busy, 1'b1);
    check_val("b2b_ce", sram_ce_n, 1'b0);
    tick();
    check_val("b2b_addr", sram_addr, 21'h00101);
    check_val("b2b_data", sram_data, 8'h11);
    repeat (4) tick();
    check_val("b2b_addr_after", sram_addr, 21'h00102);

    // 16 sequential incrementing writes
    for (int i = 0; i < 16; i++) begin
      access(1'b0, 1'b1, (i == 0), 21'h00200, 8'(i), 1'b1, we_c, oe_c, d_at, d_c, a_s, d_s, dbg_s);
    end
    check_val("seq16_addr", sram_addr, 21'h00210);
    check_val("seq16_last_data", d_s, 8'h0F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
